pipeline_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage CPU. It generates the write-enable and flush (bubble) controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken branches, instruction- and data-cache miss stalls, and HLT drain. A 16-bit saturating stall counter is exposed for performance measurement.

---
 rtl/pipeline_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central sequencer for the 5-stage CPU pipeline.
// Produces write enables and bubble (flush) controls for the PC and the
// IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards,
// taken branches, I-cache and D-cache miss stalls, and the HLT drain.
//
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   ID_Rs/ID_Rt           - source registers of the ID instruction
//   ID_UsesRs/ID_UsesRt   - ID instruction really reads Rs / Rt
//   EX_Rd, EX_MemRead     - destination and load flag of the EX instruction
//   ID_BranchTaken        - branch in ID resolved taken
//   ID_Halt               - HLT decoded in ID
//   IF_MissReq/Done       - I-cache miss level / fill-complete pulse
//   MEM_MissReq/Done      - D-cache miss level / fill-complete pulse
//   *_wen, *_flush        - pipeline register controls
//   Halted                - pipeline drained after HLT
//   StallCount            - saturating count of stalled (PC_wen = 0) cycles
module pipeline_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ID_Rs,
    input  logic [3:0]  ID_Rt,
    input  logic        ID_UsesRs,
    input  logic        ID_UsesRt,
    input  logic [3:0]  EX_Rd,
    input  logic        EX_MemRead,
    input  logic        ID_BranchTaken,
    input  logic        ID_Halt,
    input  logic        IF_MissReq,
    input  logic        IF_MissDone,
    input  logic        MEM_MissReq,
    input  logic        MEM_MissDone,
    output logic        PC_wen,
    output logic        IFID_wen,
    output logic        IDEX_wen,
    output logic        EXMEM_wen,
    output logic        MEMWB_wen,
    output logic        IFID_flush,
    output logic        IDEX_flush,
    output logic        Halted,
    output logic [15:0] StallCount
);

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StDmiss = 2'b01,
        StImiss = 2'b10,
        StHalt  = 2'b11
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  drain_q, drain_d;
    logic [15:0] stall_q, stall_d;
    logic        load_use;

    // Register 0 is hard-wired, so a load to it never creates a hazard.
    assign load_use = EX_MemRead && (EX_Rd != 4'd0) &&
                      ((ID_UsesRs && (ID_Rs == EX_Rd)) ||
                       (ID_UsesRt && (ID_Rt == EX_Rd)));

    // State register and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            drain_q <= 2'd0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            StRun: begin
                if (MEM_MissReq) begin
                    state_d = StDmiss;
                end else if (load_use || ID_BranchTaken) begin
                    // Stay in RUN; a pending I-miss is picked up next cycle.
                    state_d = StRun;
                end else if (ID_Halt) begin
                    state_d = StHalt;
                    drain_d = 2'd0;
                end else if (IF_MissReq) begin
                    state_d = StImiss;
                end
            end
            StDmiss: begin
                if (MEM_MissDone) state_d = StRun;
            end
            StImiss: begin
                // A D-miss preempts; the held IF_MissReq re-enters IMISS via RUN.
                if (MEM_MissReq)      state_d = StDmiss;
                else if (IF_MissDone) state_d = StRun;
            end
            StHalt: begin
                if (!MEM_MissReq && (drain_q != 2'd3)) drain_d = drain_q + 2'd1;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        PC_wen     = 1'b1;
        IFID_wen   = 1'b1;
        IDEX_wen   = 1'b1;
        EXMEM_wen  = 1'b1;
        MEMWB_wen  = 1'b1;
        IFID_flush = 1'b0;
        IDEX_flush = 1'b0;
        Halted     = 1'b0;
        if (rst) begin
            PC_wen    = 1'b0;
            IFID_wen  = 1'b0;
            IDEX_wen  = 1'b0;
            EXMEM_wen = 1'b0;
            MEMWB_wen = 1'b0;
        end else begin
            case (state_q)
                StRun: begin
                    if (MEM_MissReq) begin
                        {PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, MEMWB_wen} = 5'b00000;
                    end else if (load_use) begin
                        PC_wen     = 1'b0;
                        IFID_wen   = 1'b0;
                        IDEX_flush = 1'b1;
                    end else if (ID_BranchTaken) begin
                        IFID_flush = 1'b1;
                    end else if (ID_Halt || IF_MissReq) begin
                        PC_wen     = 1'b0;
                        IFID_flush = 1'b1;
                    end
                end
                StDmiss: begin
                    {PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, MEMWB_wen} = 5'b00000;
                end
                StImiss: begin
                    if (MEM_MissReq) begin
                        {PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, MEMWB_wen} = 5'b00000;
                    end else begin
                        PC_wen     = 1'b0;
                        IFID_flush = 1'b1;
                    end
                end
                StHalt: begin
                    if (MEM_MissReq) begin
                        {PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, MEMWB_wen} = 5'b00000;
                    end else begin
                        PC_wen     = 1'b0;
                        IFID_wen   = 1'b0;
                        IDEX_flush = 1'b1;
                    end
                    Halted = (drain_q == 2'd3);
                end
            endcase
        end
    end

    // Halt is a deliberate stop, not a stall, so it is excluded from the count.
    always_comb begin
        stall_d = stall_q;
        if (!PC_wen && (state_q != StHalt) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    assign StallCount = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  ID_Rs, ID_Rt, EX_Rd;
    logic        ID_UsesRs, ID_UsesRt, EX_MemRead;
    logic        ID_BranchTaken, ID_Halt;
    logic        IF_MissReq, IF_MissDone, MEM_MissReq, MEM_MissDone;
    logic        PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, MEMWB_wen;
    logic        IFID_flush, IDEX_flush, Halted;
    logic [15:0] StallCount;
    logic [6:0]  ctl;

    int total = 0;
    int bad   = 0;

    // {PC, IFID, IDEX, EXMEM, MEMWB wen, IFID flush, IDEX flush}
    localparam logic [6:0] CtlReset = 7'b0000000;
    localparam logic [6:0] CtlIdle  = 7'b1111100;
    localparam logic [6:0] CtlLdUse = 7'b0011101;
    localparam logic [6:0] CtlBr    = 7'b1111110;
    localparam logic [6:0] CtlFetch = 7'b0111110;
    localparam logic [6:0] CtlFrz   = 7'b0000000;
    localparam logic [6:0] CtlHalt  = 7'b0011101;

    assign ctl = {PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, MEMWB_wen, IFID_flush, IDEX_flush};

    pipeline_ctrl u_dut (
        .clk           (clk),
        .rst           (rst),
        .ID_Rs         (ID_Rs),
        .ID_Rt         (ID_Rt),
        .ID_UsesRs     (ID_UsesRs),
        .ID_UsesRt     (ID_UsesRt),
        .EX_Rd         (EX_Rd),
        .EX_MemRead    (EX_MemRead),
        .ID_BranchTaken(ID_BranchTaken),
        .ID_Halt       (ID_Halt),
        .IF_MissReq    (IF_MissReq),
        .IF_MissDone   (IF_MissDone),
        .MEM_MissReq   (MEM_MissReq),
        .MEM_MissDone  (MEM_MissDone),
        .PC_wen        (PC_wen),
        .IFID_wen      (IFID_wen),
        .IDEX_wen      (IDEX_wen),
        .EXMEM_wen     (EXMEM_wen),
        .MEMWB_wen     (MEMWB_wen),
        .IFID_flush    (IFID_flush),
        .IDEX_flush    (IDEX_flush),
        .Halted        (Halted),
        .StallCount    (StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        ID_Rs = 4'd0; ID_Rt = 4'd0; EX_Rd = 4'd0;
        ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; EX_MemRead = 1'b0;
        ID_BranchTaken = 1'b0; ID_Halt = 1'b0;
        IF_MissReq = 1'b0; IF_MissDone = 1'b0;
        MEM_MissReq = 1'b0; MEM_MissDone = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        settle();
        check_eq("rst_ctl", 32'(ctl), 32'(CtlReset));
        check_eq("rst_halted", 32'(Halted), 32'd0);
        check_eq("rst_stall", 32'(StallCount), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        settle();
        check_eq("idle_ctl", 32'(ctl), 32'(CtlIdle));

        // Load-use on Rs
        EX_MemRead = 1'b1; EX_Rd = 4'd4; ID_Rs = 4'd4; ID_UsesRs = 1'b1;
        settle();
        check_eq("lduse_rs", 32'(ctl), 32'(CtlLdUse));
        tick();
        clear_inputs();
        settle();
        check_eq("lduse_after", 32'(ctl), 32'(CtlIdle));
        check_eq("lduse_stall", 32'(StallCount), 32'd1);
        // Load to r0 never stalls
        EX_MemRead = 1'b1; EX_Rd = 4'd0; ID_Rs = 4'd0; ID_UsesRs = 1'b1;
        settle();
        check_eq("lduse_r0", 32'(ctl), 32'(CtlIdle));
        // Rt match
        EX_Rd = 4'd7; ID_Rt = 4'd7; ID_UsesRt = 1'b1; ID_UsesRs = 1'b0;
        settle();
        check_eq("lduse_rt", 32'(ctl), 32'(CtlLdUse));
        ID_UsesRt = 1'b0;
        settle();
        check_eq("lduse_unused", 32'(ctl), 32'(CtlIdle));
        // Load-use outranks branch and halt
        ID_UsesRt = 1'b1; ID_BranchTaken = 1'b1; ID_Halt = 1'b1;
        settle();
        check_eq("lduse_prio", 32'(ctl), 32'(CtlLdUse));
        clear_inputs();
        settle();

        // Branch with concurrent I-miss
        ID_BranchTaken = 1'b1; IF_MissReq = 1'b1;
        settle();
        check_eq("br_ctl", 32'(ctl), 32'(CtlBr));
        tick();
        ID_BranchTaken = 1'b0;
        settle();
        check_eq("imiss_entry", 32'(ctl), 32'(CtlFetch));
        check_eq("br_stall", 32'(StallCount), 32'd1);
        tick();
        // In IMISS outputs hold even with the request momentarily low
        IF_MissReq = 1'b0;
        settle();
        check_eq("imiss_state", 32'(ctl), 32'(CtlFetch));
        IF_MissReq = 1'b1;
        check_eq("imiss_stall", 32'(StallCount), 32'd2);
        tick();

        // Nested D-miss at 2nd IMISS cycle
        MEM_MissReq = 1'b1;
        settle();
        check_eq("nest_frz0", 32'(ctl), 32'(CtlFrz));
        tick();
        settle();
        check_eq("nest_frz1", 32'(ctl), 32'(CtlFrz));
        tick();
        tick();
        MEM_MissReq = 1'b0; MEM_MissDone = 1'b1;
        settle();
        check_eq("nest_done", 32'(ctl), 32'(CtlFrz));
        tick();
        MEM_MissDone = 1'b0;
        ID_BranchTaken = 1'b1;
        settle();
        check_eq("nest_run", 32'(ctl), 32'(CtlBr));
        ID_BranchTaken = 1'b0;
        settle();
        check_eq("nest_reimiss", 32'(ctl), 32'(CtlFetch));
        tick();
        ID_BranchTaken = 1'b1;
        settle();
        check_eq("imiss_ignore_br", 32'(ctl), 32'(CtlFetch));
        ID_BranchTaken = 1'b0;
        IF_MissReq = 1'b0; IF_MissDone = 1'b1;
        settle();
        check_eq("imiss_done", 32'(ctl), 32'(CtlFetch));
        tick();
        IF_MissDone = 1'b0;
        settle();
        check_eq("imiss_exit", 32'(ctl), 32'(CtlIdle));
        check_eq("imiss_total", 32'(StallCount), 32'd9);

        // D-miss: 5 request cycles plus the done cycle
        for (int i = 0; i < 5; i++) begin
            MEM_MissReq = 1'b1;
            settle();
            check_eq("dmiss_req", 32'(ctl), 32'(CtlFrz));
            tick();
        end
        MEM_MissReq = 1'b0; MEM_MissDone = 1'b1;
        settle();
        check_eq("dmiss_done", 32'(ctl), 32'(CtlFrz));
        tick();
        MEM_MissDone = 1'b0;
        settle();
        check_eq("dmiss_exit", 32'(ctl), 32'(CtlIdle));
        check_eq("dmiss_stall", 32'(StallCount), 32'd15);

        // Reset in the middle of a D-miss
        MEM_MissReq = 1'b1;
        tick();
        rst = 1'b1;
        settle();
        check_eq("rstmid_ctl", 32'(ctl), 32'(CtlReset));
        check_eq("rstmid_stall", 32'(StallCount), 32'd0);
        tick();
        rst = 1'b0; MEM_MissReq = 1'b0;
        settle();
        check_eq("rstmid_run", 32'(ctl), 32'(CtlIdle));

        // Halt and drain, with one frozen cycle
        ID_Halt = 1'b1;
        settle();
        check_eq("halt_dec", 32'(ctl), 32'(CtlFetch));
        tick();
        ID_Halt = 1'b0;
        settle();
        check_eq("halt_ctl", 32'(ctl), 32'(CtlHalt));
        check_eq("halt_h0", 32'(Halted), 32'd0);
        MEM_MissReq = 1'b1;
        settle();
        check_eq("halt_frz", 32'(ctl), 32'(CtlFrz));
        tick();
        MEM_MissReq = 1'b0;
        settle();
        check_eq("halt_frz_h", 32'(Halted), 32'd0);
        tick();
        check_eq("halt_h1", 32'(Halted), 32'd0);
        tick();
        check_eq("halt_h2", 32'(Halted), 32'd0);
        tick();
        check_eq("halt_h3", 32'(Halted), 32'd1);
        ID_BranchTaken = 1'b1; IF_MissReq = 1'b1;
        settle();
        check_eq("halt_ignore", 32'(ctl), 32'(CtlHalt));
        tick();
        tick();
        check_eq("halt_stay", 32'(Halted), 32'd1);
        check_eq("halt_stall", 32'(StallCount), 32'd1);
        rst = 1'b1;
        settle();
        check_eq("halt_rst", 32'(Halted), 32'd0);
        clear_inputs();
        tick();
        rst = 1'b0;
        settle();
        check_eq("halt_rst_run", 32'(ctl), 32'(CtlIdle));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
